// File: rtl/ocm_noise_reader_pkg.sv
// Shared definitions for the noise on-chip memory read master: default geometry,
// FSM state encoding and the tag carried alongside each in-flight read.
package ocm_noise_reader_pkg;

    localparam int OCM_DATA_W    = 64;
    localparam int OCM_ADDR_W    = 14;
    localparam int OCM_MEM_DEPTH = 8960;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
    } rd_tag_t;

endpackage

// File: rtl/ocm_rd_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous clear, used to
// buffer words returning from the fixed-latency memory read port.
module ocm_rd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count/pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ocm_noise_reader.sv
// Read master for the noise on-chip memory: fetches a programmed window of words
// and streams them out through a credit-managed prefetch FIFO.
module ocm_noise_reader
    import ocm_noise_reader_pkg::*;
#(
    parameter int DATA_W       = OCM_DATA_W,
    parameter int ADDR_W       = OCM_ADDR_W,
    parameter int MEM_DEPTH    = OCM_MEM_DEPTH,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              loop_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ocm_address,
    output logic              ocm_chipselect,
    output logic              ocm_write,
    output logic [7:0]        ocm_byteenable,
    output logic [DATA_W-1:0] ocm_writedata,
    output logic              ocm_clken,
    input  logic [DATA_W-1:0] ocm_readdata,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
    localparam int FL_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t            state;
    logic [ADDR_W-1:0] base_q, num_q, issued, addr_q;
    logic [ADDR_W-1:0] eff_issued, cfg_base, cfg_num, nxt_addr;
    logic              loop_q, cs_q, last_q;
    logic              start_go, flush_go, issue, credit_ok, drain_done, tags_busy;
    logic              push, pop, clr;
    logic [FL_W-1:0]   flush_cnt;
    logic [OCC_W-1:0]  occ;
    rd_tag_t           tag_pipe [READ_LATENCY];
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty;
    logic [DATA_W:0]   fifo_head;

    assign ocm_write      = 1'b0;
    assign ocm_byteenable = 8'hFF;
    assign ocm_writedata  = '0;
    assign ocm_clken      = 1'b1;
    assign ocm_address    = addr_q;
    assign ocm_chipselect = cs_q;
    assign busy           = (state != ST_IDLE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tags_busy = 1'b0;
        occ       = OCC_W'(fifo_count) + OCC_W'(cs_q);
        for (int i = 0; i < READ_LATENCY; i++) begin
            tags_busy = tags_busy | tag_pipe[i].valid;
            occ       = occ + OCC_W'(tag_pipe[i].valid);
        end
    end

    // Occupancy counts the word on the bus and every tagged read, so a granted
    // read always finds a free FIFO slot when its data returns.
    assign credit_ok = !fifo_full && (occ < OCC_W'(FIFO_DEPTH));
    assign start_go  = start && !abort && (state == ST_IDLE);
    assign flush_go  = abort && (state == ST_RUN || state == ST_DRAIN);
    assign cfg_base  = (state == ST_IDLE) ? base_addr : base_q;
    assign cfg_num   = (state == ST_IDLE) ? num_words : num_q;
    assign eff_issued = ((state == ST_IDLE) || (issued == num_q && loop_q)) ? '0 : issued;
    assign issue     = (start_go || (state == ST_RUN && !abort)) &&
                       (eff_issued != cfg_num) && credit_ok;
    assign nxt_addr  = (eff_issued == '0)                      ? cfg_base :
                       (addr_q == ADDR_W'(MEM_DEPTH - 1))      ? '0       :
                                                                 addr_q + 1'b1;

    assign pop        = !fifo_empty && m_ready;
    assign clr        = flush_go || (state == ST_FLUSH);
    assign push       = tag_pipe[READ_LATENCY-1].valid && !clr;
    assign drain_done = !tags_busy && !cs_q &&
                        (fifo_empty || (fifo_count == CNT_W'(1) && pop));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            num_q     <= '0;
            loop_q    <= 1'b0;
            issued    <= '0;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            last_q    <= 1'b0;
            done      <= 1'b0;
            flush_cnt <= '0;
        end else begin
            done   <= 1'b0;
            cs_q   <= issue;
            last_q <= issue && (eff_issued + 1'b1 == cfg_num);
            issued <= issue ? eff_issued + 1'b1 : eff_issued;
            if (issue) addr_q <= nxt_addr;
            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        base_q <= base_addr;
                        num_q  <= num_words;
                        loop_q <= loop_en;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush_go) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end else if (issued == num_q && !loop_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (flush_go) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end else if (drain_done) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FL_W'(READ_LATENCY - 1)) state <= ST_IDLE;
                    else                                      flush_cnt <= flush_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: cs_q, last: last_q};
            for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    ocm_rd_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .push      (push),
        .push_data ({tag_pipe[READ_LATENCY-1].last, ocm_readdata}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign m_last  = !fifo_empty && fifo_head[DATA_W];

endmodule
